pc_ctrl_p: RTL and testbench

Execute-stage control-flow resolver and hazard controller for the 5-stage RV32I pipeline. It drives `PC_Target`, `PCsrc` and `en` into the PC unit, and stall/flush controls into the IF/ID and ID/EX registers. It resolves branches and jumps in EX, detects load-use hazards against the instruction in ID, and sequences a one-cycle stall FSM. Optional saturating performance counters record redirects and stalls.

---
 rtl/pc_ctrl_p.sv | 153 +++++++++++++++
 tb/tb_pc_ctrl_p.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_p.sv
// pc_ctrl_p: execute-stage control-flow resolver and hazard controller for
// the 5-stage RV32I pipeline.
//   - Resolves conditional branches, JAL and JALR in EX and drives the PC
//     redirect (PC_Target / PCsrc) plus IF/ID and ID/EX flushes.
//   - Detects load-use hazards against the ID instruction and sequences a
//     one-cycle RUN/STALL FSM (pc_en / ifid_en / idex_flush / stall_active).
//   - Optional saturating performance counters, built only when the macro
//     PC_CTRL_PERF_EN is defined; otherwise cnt_* are tied to zero.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_*                         EX-stage instruction attributes and operands
//   id_rs1, id_rs2               ID-stage source registers
//   PC_Target, PCsrc, pc_en      PC unit controls (combinational)
//   ifid_en, ifid_flush          IF/ID register controls (combinational)
//   idex_flush                   ID/EX register bubble insert (combinational)
//   stall_active                 FSM is in STALL
//   cnt_redirect, cnt_stall      performance counters
module pc_ctrl_p #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [WIDTH-1:0] ex_rs1_val,
    input  logic [WIDTH-1:0] ex_rs2_val,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_imm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic [WIDTH-1:0] PC_Target,
    output logic             PCsrc,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             stall_active,
    output logic [31:0]      cnt_redirect,
    output logic [31:0]      cnt_stall
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state, state_next;

    logic taken;
    logic redirect;
    logic lu;
    logic stall_enter;

    // Branch condition evaluation
    always_comb begin
        taken = 1'b0;
        case (ex_funct3)
            3'b000:  taken = (ex_rs1_val == ex_rs2_val);
            3'b001:  taken = (ex_rs1_val != ex_rs2_val);
            3'b100:  taken = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
            3'b101:  taken = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
            3'b110:  taken = (ex_rs1_val <  ex_rs2_val);
            3'b111:  taken = (ex_rs1_val >= ex_rs2_val);
            default: taken = 1'b0;
        endcase
    end

    assign redirect = ex_valid & ((ex_branch & taken) | ex_jal | ex_jalr);

    // Redirect target; sums wrap modulo 2^WIDTH, JALR clears bit 0
    always_comb begin
        if (ex_jalr) begin
            PC_Target = (ex_rs1_val + ex_imm) & ~WIDTH'(1);
        end else begin
            PC_Target = ex_pc + ex_imm;
        end
    end

    // Load in EX whose destination is read by the ID instruction
    assign lu = ex_valid & ex_memread & (ex_rd != 5'd0) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A redirect squashes ID anyway, so it overrides the stall
    assign stall_enter = (state == RUN) & lu & ~redirect;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; STALL always lasts exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            RUN:     state_next = stall_enter ? STALL : RUN;
            STALL:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        PCsrc        = redirect;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = redirect;
        idex_flush   = redirect;
        stall_active = (state == STALL);
        if (stall_enter) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef PC_CTRL_PERF_EN
    logic [CNT_W-1:0] redirect_q;
    logic [CNT_W-1:0] stall_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q <= '0;
            stall_q    <= '0;
        end else begin
            if (redirect && (redirect_q != '1)) begin
                redirect_q <= redirect_q + CNT_W'(1);
            end
            if (stall_enter && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign cnt_redirect = redirect_q;
    assign cnt_stall    = stall_q;
`else
    assign cnt_redirect = CNT_W'(0);
    assign cnt_stall    = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pc_ctrl_p.sv
// Testbench for pc_ctrl_p: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling edge.
module tb_pc_ctrl_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr, ex_memread;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1_val, ex_rs2_val, ex_pc, ex_imm;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic [31:0] PC_Target;
    logic        PCsrc, pc_en, ifid_en, ifid_flush, idex_flush, stall_active;
    logic [31:0] cnt_redirect, cnt_stall;

    int checks = 0;
    int fails  = 0;

    pc_ctrl_p #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_funct3(ex_funct3),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .PC_Target(PC_Target), .PCsrc(PCsrc), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_active(stall_active),
        .cnt_redirect(cnt_redirect), .cnt_stall(cnt_stall)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit      m_valid = 1'b0;   // model state known once a reset edge has passed
    bit      m_stall = 1'b0;   // previous cycle started a bubble
    longint  m_cnt_r = 0;
    longint  m_cnt_s = 0;

    bit          e_redir, e_stall_req;
    logic [31:0] e_target;

    function automatic bit cond_holds(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        case (f3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return !(sa < sb);
            3'd6: return ua < ub;
            3'd7: return !(ua < ub);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        longint sum;
        bit lu_m;
        e_redir = ex_valid && ((ex_branch && cond_holds(ex_funct3, ex_rs1_val, ex_rs2_val))
                               || ex_jal || ex_jalr);
        if (ex_jalr) sum = (longint'({32'd0, ex_rs1_val}) + longint'({32'd0, ex_imm})) % 64'h1_0000_0000;
        else         sum = (longint'({32'd0, ex_pc}) + longint'({32'd0, ex_imm})) % 64'h1_0000_0000;
        if (ex_jalr && (sum % 2 == 1)) sum = sum - 1;
        e_target = 32'(sum);
        lu_m = ex_valid && ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        e_stall_req = !m_stall && lu_m && !e_redir;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_stall = 1'b0;
            m_cnt_r = 0;
            m_cnt_s = 0;
        end else begin
            if (e_redir)     m_cnt_r = m_cnt_r + 1;
            if (e_stall_req) m_cnt_s = m_cnt_s + 1;
            m_stall = e_stall_req;
        end
        if (rst) m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_PCsrc",        32'(PCsrc),        32'(e_redir));
            chk("m_pc_en",        32'(pc_en),        32'(!e_stall_req));
            chk("m_ifid_en",      32'(ifid_en),      32'(!e_stall_req));
            chk("m_ifid_flush",   32'(ifid_flush),   32'(e_redir));
            chk("m_idex_flush",   32'(idex_flush),   32'(e_redir || e_stall_req));
            chk("m_stall_active", 32'(stall_active), 32'(m_stall));
            if (e_redir) chk("m_PC_Target", PC_Target, e_target);
`ifdef PC_CTRL_PERF_EN
            chk("m_cnt_redirect", cnt_redirect, 32'(m_cnt_r));
            chk("m_cnt_stall",    cnt_stall,    32'(m_cnt_s));
`else
            chk("m_cnt_redirect", cnt_redirect, 32'd0);
            chk("m_cnt_stall",    cnt_stall,    32'd0);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_in();
        ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_memread = 0;
        ex_funct3 = 3'd0; ex_rs1_val = 0; ex_rs2_val = 0; ex_pc = 0; ex_imm = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm);
        clear_in();
        ex_valid = 1; ex_branch = 1; ex_funct3 = f3;
        ex_rs1_val = a; ex_rs2_val = b; ex_pc = pc; ex_imm = imm;
    endtask

    task automatic load_use(input logic [4:0] rd);
        clear_in();
        ex_valid = 1; ex_memread = 1; ex_rd = rd; id_rs1 = 5'd0; id_rs2 = 5'd5;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick(); tick();
        sample();
        chk("rst_PCsrc", 32'(PCsrc), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_ifid_en", 32'(ifid_en), 32'd1);
        chk("rst_flushes", {30'd0, ifid_flush, idex_flush}, 32'd0);
        chk("rst_stall_active", 32'(stall_active), 32'd0);
        chk("rst_cnt", cnt_redirect | cnt_stall, 32'd0);
        tick();
        rst = 1'b0;

        branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        sample();
        chk("beq_PCsrc", 32'(PCsrc), 32'd1);
        chk("beq_target", PC_Target, 32'h120);
        chk("beq_flushes", {30'd0, ifid_flush, idex_flush}, 32'd3);
        tick();

        branch(3'b000, 32'd5, 32'd6, 32'h100, 32'h20);
        sample();
        chk("beq_nt_PCsrc", 32'(PCsrc), 32'd0);
        chk("beq_nt_flushes", {30'd0, ifid_flush, idex_flush}, 32'd0);
        tick();

        branch(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        sample();
        chk("blt_PCsrc", 32'(PCsrc), 32'd1);
        tick();
        branch(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        sample();
        chk("bltu_PCsrc", 32'(PCsrc), 32'd0);
        tick();
        branch(3'b010, 32'd7, 32'd7, 32'h200, 32'h40);
        sample();
        chk("f010_PCsrc", 32'(PCsrc), 32'd0);
        tick();
        branch(3'b111, 32'h8000_0000, 32'd1, 32'h300, 32'hFFFF_FFF0);
        sample();
        chk("bgeu_target", PC_Target, 32'h2F0);
        tick();

        clear_in(); ex_valid = 1; ex_jalr = 1; ex_rs1_val = 32'h1003; ex_imm = 32'd4;
        ex_pc = 32'h500;
        sample();
        chk("jalr_target", PC_Target, 32'h1006);
        chk("jalr_PCsrc", 32'(PCsrc), 32'd1);
        tick();

        clear_in(); ex_valid = 1; ex_jal = 1; ex_pc = 32'hFFFF_FFFC; ex_imm = 32'd8;
        sample();
        chk("jal_wrap_target", PC_Target, 32'h0000_0004);
        tick();

        // Load-use: detect, one STALL cycle (repeat hazard ignored), back to RUN
        load_use(5'd5);
        sample();
        chk("lu_detect_en", {30'd0, pc_en, ifid_en}, 32'd0);
        chk("lu_detect_flush", 32'(idex_flush), 32'd1);
        tick();
        sample();
        chk("lu_stall_active", 32'(stall_active), 32'd1);
        chk("lu_stall_pc_en", 32'(pc_en), 32'd1);
        tick();
        clear_in();
        sample();
        chk("lu_back_run", 32'(stall_active), 32'd0);
        tick();

        load_use(5'd0); id_rs2 = 5'd0;
        sample();
        chk("lu_rd0_pc_en", 32'(pc_en), 32'd1);
        tick();
        clear_in();
        sample();
        chk("lu_rd0_no_stall", 32'(stall_active), 32'd0);
        tick();

        // Reset while stalled
        load_use(5'd5);
        tick();
        clear_in(); rst = 1'b1;
        sample();
        chk("pre_rst_stall", 32'(stall_active), 32'd1);
        tick();
        sample();
        chk("rst_in_stall_state", 32'(stall_active), 32'd0);
        chk("rst_in_stall_pc_en", 32'(pc_en), 32'd1);
        tick();
        rst = 1'b0;

        // Redirect honoured in STALL; counters start from the reset above
        load_use(5'd5);
        tick();
        branch(3'b001, 32'd1, 32'd2, 32'h40, 32'h10);
        sample();
        chk("stall_redir_state", 32'(stall_active), 32'd1);
        chk("stall_redir_PCsrc", 32'(PCsrc), 32'd1);
        chk("stall_redir_flushes", {30'd0, ifid_flush, idex_flush}, 32'd3);
        chk("stall_redir_pc_en", 32'(pc_en), 32'd1);
        tick();
        clear_in(); ex_valid = 1; ex_jal = 1; ex_pc = 32'h80; ex_imm = 32'h8;
        tick();
        branch(3'b101, 32'd3, 32'hFFFF_FFFE, 32'h90, 32'h4);
        tick();
        load_use(5'd5);
        tick();
        clear_in();
        tick();
        sample();
`ifdef PC_CTRL_PERF_EN
        chk("cnt_redirect_3", cnt_redirect, 32'd3);
        chk("cnt_stall_2", cnt_stall, 32'd2);
`else
        chk("cnt_redirect_off", cnt_redirect, 32'd0);
        chk("cnt_stall_off", cnt_stall, 32'd0);
`endif
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
